key_event_ctrl: RTL and testbench

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_codes.sv | 21 ++
 rtl/key_event_fifo.sv | 40 ++++
 rtl/key_event_ctrl.sv | 124 ++++++++++++
 tb/tb_key_event_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_codes.sv
// key_codes: key code values, controller FSM states and the event record shared by the key event blocks.
package key_codes;
    localparam int CNT_W = 16;
    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_UP    = 3'd1,
        KEY_DOWN  = 3'd2,
        KEY_LEFT  = 3'd3,
        KEY_RIGHT = 3'd4
    } key_t;
    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        REPEAT
    } state_t;
    typedef struct packed {
        logic [2:0] code;
        logic       rpt;
    } event_t;
endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: 4-entry first-in first-out queue of key events; push and pop may coincide even when full.
module key_event_fifo
    import key_codes::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  event_t din,
    output event_t dout,
    output logic   full,
    output logic   empty
);
    event_t     mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       do_pop;
    logic       do_push;
    assign empty   = count == 3'd0;
    assign full    = count == 3'd4;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (do_pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, do_push} - {2'b0, do_pop};
        end
    end
    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounces the touch-pad key code, emits press and auto-repeat events into a 4-deep FIFO.
module key_event_ctrl
    import key_codes::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int REPEAT_DLY   = 1000,
    parameter int REPEAT_PER   = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] keys_in,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [2:0] ev_code,
    output logic       ev_repeat,
    output logic [2:0] held,
    output logic       overflow
);
    localparam logic [CNT_W-1:0] DB  = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] DLY = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] PER = CNT_W'(REPEAT_PER);
    state_t             state;
    state_t             state_n;
    logic [2:0]         cand;
    logic [2:0]         cand_n;
    logic [2:0]         held_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   tmr;
    logic [CNT_W-1:0]   tmr_n;
    logic [CNT_W-1:0]   tmr_inc;
    logic               rel;
    logic               push;
    event_t             push_ev;
    event_t             head;
    logic               full;
    logic               empty;
    assign cnt_inc = cnt + 1'b1;
    assign tmr_inc = tmr + 1'b1;
    assign rel     = keys_in != held;
    // cnt is the debounce counter before acceptance and the release counter while held.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        held_n  = held;
        cnt_n   = cnt;
        tmr_n   = tmr;
        push    = 1'b0;
        push_ev = '{code: held, rpt: 1'b1};
        case (state)
            IDLE: begin
                if (keys_in != KEY_NONE) begin
                    cand_n  = keys_in;
                    cnt_n   = '0;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (keys_in == KEY_NONE) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (keys_in != cand) begin
                    cand_n = keys_in;
                    cnt_n  = '0;
                end else if (cnt_inc == DB) begin
                    held_n  = cand;
                    push    = 1'b1;
                    push_ev = '{code: cand, rpt: 1'b0};
                    cnt_n   = '0;
                    tmr_n   = '0;
                    state_n = PRESSED;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                cnt_n = rel ? cnt_inc : '0;
                tmr_n = tmr_inc;
                // An accepted release wins over a repeat falling due on the same cycle.
                if (rel && cnt_inc == DB) begin
                    held_n  = KEY_NONE;
                    cnt_n   = '0;
                    tmr_n   = '0;
                    state_n = IDLE;
                end else if (tmr_inc == (state == PRESSED ? DLY : PER)) begin
                    push    = 1'b1;
                    tmr_n   = '0;
                    state_n = REPEAT;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cand     <= KEY_NONE;
            held     <= KEY_NONE;
            cnt      <= '0;
            tmr      <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            cand     <= cand_n;
            held     <= held_n;
            cnt      <= cnt_n;
            tmr      <= tmr_n;
            overflow <= push && full && !ev_ready;
        end
    end
    key_event_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (ev_ready),
        .din   (push_ev),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    assign ev_valid  = !empty;
    assign ev_code   = head.code;
    assign ev_repeat = head.rpt;
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed scenarios plus random key traffic checked against a run-length/age reference model.
module tb_key_event_ctrl;
    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] keys_in;
    logic       ev_ready;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic       ev_repeat;
    logic [2:0] held;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base;
    int ovf_seen;

    logic [2:0] m_held;
    logic [2:0] m_rk;
    int         m_r;
    int         m_age;
    int         m_rl;
    logic [3:0] mq[$];
    logic       m_ovf;

    logic [2:0] got_code[$];
    logic       got_rep[$];
    int         got_cyc[$];

    always #5 clk = ~clk;

    key_event_ctrl #(.DEBOUNCE_CYC(DEB), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
        .clk       (clk),
        .reset     (reset),
        .keys_in   (keys_in),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_repeat (ev_repeat),
        .held      (held),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 3'd0;
        m_rk   = 3'd0;
        m_r    = 0;
        m_age  = 0;
        m_rl   = 0;
        m_ovf  = 1'b0;
        mq.delete();
    endtask

    // Press: same nonzero key seen on DEB+1 consecutive edges while nothing is held.
    // Repeats: at press age DLY, DLY+PER, ... ; release: DEB consecutive edges differing from held.
    task automatic model_edge(input logic [2:0] k, input logic r);
        logic       pop;
        logic       push;
        logic [3:0] pd;
        pop  = (mq.size() > 0) && r;
        push = 1'b0;
        pd   = 4'h0;
        if (m_held == 3'd0) begin
            if (k == 3'd0) m_r = 0;
            else if (k == m_rk && m_r > 0) m_r++;
            else begin
                m_rk = k;
                m_r  = 1;
            end
            if (m_r == DEB + 1) begin
                m_held = k;
                push   = 1'b1;
                pd     = {k, 1'b0};
                m_age  = 0;
                m_rl   = 0;
                m_r    = 0;
            end
        end else begin
            m_age++;
            m_rl = (k != m_held) ? m_rl + 1 : 0;
            if (m_rl == DEB) begin
                m_held = 3'd0;
                m_r    = 0;
            end else if (m_age >= DLY && (m_age - DLY) % PER == 0) begin
                push = 1'b1;
                pd   = {m_held, 1'b1};
            end
        end
        if (pop) void'(mq.pop_front());
        m_ovf = 1'b0;
        if (push) begin
            if (mq.size() < 4) mq.push_back(pd);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic compare_all();
        logic [3:0] h;
        h = (mq.size() > 0) ? mq[0] : 4'h0;
        chk("ev_valid", int'(ev_valid), int'(mq.size() > 0));
        chk("ev_code", int'(ev_code), int'(h[3:1]));
        chk("ev_repeat", int'(ev_repeat), int'(h[0]));
        chk("held", int'(held), int'(m_held));
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic step(input logic [2:0] k, input logic r);
        keys_in  = k;
        ev_ready = r;
        if (ev_valid && r) begin
            got_code.push_back(ev_code);
            got_rep.push_back(ev_repeat);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        model_edge(k, r);
        #1;
        if (overflow) ovf_seen++;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    task automatic clear_obs();
        got_code.delete();
        got_rep.delete();
        got_cyc.delete();
        ovf_seen = 0;
        base = cyc;
    endtask

    task automatic press(input logic [2:0] k, input logic r);
        repeat (6) step(k, r);
        repeat (5) step(3'd0, r);
    endtask

    initial begin
        int       len;
        logic [2:0] k;
        logic [2:0] seq036[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        logic [2:0] exp037[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2};
        int       dly035[4] = '{0, 20, 28, 36};
        reset    = 1'b1;
        keys_in  = 3'd0;
        ev_ready = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Stable key 1: one initial event right after debounce, nothing else before cycle 24.
        clear_obs();
        repeat (24) step(3'd1, 1'b1);
        chk("s033_count", got_code.size(), 1);
        chk("s033_event", got_code.size() > 0 ? int'({got_code[0], got_rep[0]}) : -1, 4'b0010);
        chk("s033_latency", got_cyc.size() > 0 ? got_cyc[0] - base : -1, 5);
        repeat (8) step(3'd0, 1'b1);

        // Short glitch never accepted.
        clear_obs();
        repeat (3) step(3'd2, 1'b1);
        repeat (6) step(3'd0, 1'b1);
        chk("s034_count", got_code.size(), 0);
        chk("s034_held", int'(held), 0);

        // Auto-repeat cadence.
        clear_obs();
        repeat (44) step(3'd3, 1'b1);
        repeat (8) step(3'd0, 1'b1);
        chk("s035_count", got_code.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s035_code%0d", i), i < got_code.size() ? int'(got_code[i]) : -1, 3);
            chk($sformatf("s035_rep%0d", i), i < got_rep.size() ? int'(got_rep[i]) : -1, i > 0 ? 1 : 0);
            chk($sformatf("s035_delay%0d", i), i < got_cyc.size() ? got_cyc[i] - got_cyc[0] : -1, dly035[i]);
        end

        // Fifth press into a full FIFO is dropped.
        clear_obs();
        for (int i = 0; i < 5; i++) press(seq036[i], 1'b0);
        chk("s036_ovf_pulses", ovf_seen, 1);
        repeat (8) step(3'd0, 1'b1);
        chk("s036_drain_count", got_code.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("s036_drain%0d", i), i < got_code.size() ? int'(got_code[i]) : -1, int'(seq036[i]));

        // Push and pop together while full.
        clear_obs();
        for (int i = 1; i <= 4; i++) press(3'(i), 1'b0);
        repeat (4) step(3'd2, 1'b0);
        step(3'd2, 1'b1);
        chk("s037_overflow", int'(overflow), 0);
        chk("s037_valid", int'(ev_valid), 1);
        repeat (5) step(3'd0, 1'b0);
        repeat (8) step(3'd0, 1'b1);
        chk("s037_ovf_pulses", ovf_seen, 0);
        chk("s037_drain_count", got_code.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("s037_drain%0d", i), i < got_code.size() ? int'(got_code[i]) : -1, int'(exp037[i]));

        // Reset during REPEAT with the key still down.
        repeat (30) step(3'd3, 1'b1);
        do_reset();
        chk("s038_held", int'(held), 0);
        clear_obs();
        repeat (8) step(3'd3, 1'b1);
        chk("s038_count", got_code.size(), 1);
        chk("s038_event", got_code.size() > 0 ? int'({got_code[0], got_rep[0]}) : -1, 4'b0110);
        chk("s038_latency", got_cyc.size() > 0 ? got_cyc[0] - base : -1, 5);
        repeat (6) step(3'd0, 1'b1);

        // Random key traffic, random back-pressure, occasional resets.
        for (int s = 0; s < 160; s++) begin
            k   = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            len = $urandom_range(1, 32);
            for (int j = 0; j < len; j++)
                step(($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : k, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
